xbar_packet_scheduler: RTL
==========================

Name: xbar_packet_scheduler

Overview:
- Packet-locking, registered arbitration core for the streaming crossbar.
- One independent arbiter FSM per master port. It selects a source whose dest targets that master, holds the grant for the whole packet until the last beat transfers, and generates the per-port valid/ready/last/id and the grant matrix that drives the data muxes.
- Arbitration mode is parametrised: round-robin or fixed priority.
- Unlike the previous combinational scheduler, the handshake is true ready/valid with back-pressure.

Parameters:
S_DATA_COUNT, 3, number of source (slave-side) ports
M_DATA_COUNT, 3, number of master ports
T_ID___WIDTH, $clog2(S_DATA_COUNT), width of per-master source id
T_DEST_WIDTH, $clog2(M_DATA_COUNT), width of per-source dest field
ARB_MODE, 0, 0 = round-robin (pointer advances past last winner), 1 = fixed priority (lowest source index wins)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
s_dest_i  input  T_DEST_WIDTH*S_DATA_COUNT  per-source destination, must be stable while that source is locked
s_valid_i  input  S_DATA_COUNT  per-source valid
s_last_i  input  S_DATA_COUNT  per-source last beat of packet
m_ready_i  input  M_DATA_COUNT  per-master ready from downstream
s_ready_o  output  S_DATA_COUNT  per-source ready
m_valid_o  output  M_DATA_COUNT  per-master valid
m_last_o  output  M_DATA_COUNT  per-master last
m_id_o  output  M_DATA_COUNT*T_ID___WIDTH  source index currently locked to each master
grant_o  output  S_DATA_COUNT*M_DATA_COUNT  one-hot per master (slice m = bits m*S +: S), registered
busy_o  output  M_DATA_COUNT  master m is in LOCKED
dest_err_o  output  S_DATA_COUNT  combinational: s_valid_i high and s_dest_i >= M_DATA_COUNT

Behaviour:
- Reset (rst=1 at an edge): every master FSM goes to IDLE and every RR pointer to 0. grant_o, m_id_o and busy_o become 0. m_valid_o, m_last_o and s_ready_o are 0 while in IDLE.
- Per-master FSM states IDLE and LOCKED.
- Request for master m from source i: s_valid_i[i] & (s_dest_i[i] == m) & source i not locked by any master.
- IDLE -> LOCKED: on an edge where the request vector is nonzero, register a one-hot grant to the winner and set m_id_o to its index.
- Winner selection:
  - RR: first requester at or after the pointer, wrapping modulo S_DATA_COUNT.
  - Fixed: lowest index.
- Latency: first beat of a packet can transfer 1 cycle after valid is seen in IDLE. No combinational path from s_valid_i to grant_o.
- LOCKED, granted source g:
  - m_valid_o[m] = s_valid_i[g]; m_last_o[m] = s_last_i[g].
  - s_ready_o[g] = m_ready_i[m].
  - Transfer occurs when s_valid_i[g] & m_ready_i[m].
- LOCKED -> IDLE: on a transfer with s_last_i[g]=1. Grant clears and m_id_o returns to 0 at that edge. RR pointer becomes (g+1) mod S_DATA_COUNT; in fixed mode the pointer is unused.
- Exactly one idle bubble cycle separates consecutive packets on the same master.
- Valid deasserted mid-packet: stay LOCKED, outputs follow valid, no re-arbitration.
- m_ready_i low: stay LOCKED, no transfer.
- s_dest_i changes while locked: ignored; the grant is bound to the source index.
- Sources that are not granted get s_ready_o = 0.
- A source locked by master A is excluded from all other masters' requests.
- Out-of-range dest: never granted, s_ready_o stays 0, dest_err_o high.
- Simultaneous events on one edge: a last-beat transfer on master m and a new request for m resolve as LOCKED->IDLE first; the new request is arbitrated on the following edge.
- Independent masters update in the same cycle without interaction.
- rst asserted mid-packet: all state returns to IDLE on that edge. The partial packet is abandoned, with no flush.

Test Plan:
- Reset: hold rst 2 cycles with all s_valid_i=1 -> grant_o=0, m_valid_o=0, s_ready_o=0, busy_o=0; first grant appears the cycle after rst falls.
- RR fairness (ARB_MODE=0): sources 0,1,2 all target master 1, each sending 1-beat packets, m_ready_i=all 1 -> m_id_o slice 1 sequence 0,1,2,0 with one idle cycle between packets.
- Fixed priority (ARB_MODE=1): same stimulus -> source 0 always wins while it keeps requesting; source 2 is granted only when sources 0 and 1 are idle.
- Packet lock with back-pressure: source 2 sends a 4-beat packet to master 0, m_ready_i[0] toggles 1,0,1,0 and source 0 requests master 0 midway -> grant stays on source 2 until 4 transfers complete including last, then source 0 is granted.
- Parallel plus error: source 0 targets master 0, source 1 targets master 2, and source 2 has dest=3 with M_DATA_COUNT=3 -> both legal packets flow concurrently; dest_err_o[2]=1 and s_ready_o[2]=0 throughout.
- Reset mid-packet: assert rst on beat 2 of 5 -> busy_o=0 and grant_o=0 after the edge; the remaining beats are re-arbitrated as a new packet.

Source files
------------

// File: rtl/xbar_packet_scheduler.sv
// Packet-locking arbitration core for the streaming crossbar.
// Each master port runs its own IDLE/LOCKED arbiter. A grant is taken on a
// registered edge and held until the last beat of the packet transfers. The
// registered one-hot grant matrix steers the data muxes, and the per-port
// handshake is forwarded through the current grant.
module xbar_packet_scheduler #(
    parameter int S_DATA_COUNT = 3,
    parameter int M_DATA_COUNT = 3,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT),
    parameter int ARB_MODE     = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0]   s_dest_i,
    input  logic [S_DATA_COUNT-1:0]                s_valid_i,
    input  logic [S_DATA_COUNT-1:0]                s_last_i,
    input  logic [M_DATA_COUNT-1:0]                m_ready_i,
    output logic [S_DATA_COUNT-1:0]                s_ready_o,
    output logic [M_DATA_COUNT-1:0]                m_valid_o,
    output logic [M_DATA_COUNT-1:0]                m_last_o,
    output logic [M_DATA_COUNT*T_ID___WIDTH-1:0]   m_id_o,
    output logic [S_DATA_COUNT*M_DATA_COUNT-1:0]   grant_o,
    output logic [M_DATA_COUNT-1:0]                busy_o,
    output logic [S_DATA_COUNT-1:0]                dest_err_o
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    // Flattened registered grant matrix, slice m = bits m*S +: S.
    logic [S_DATA_COUNT*M_DATA_COUNT-1:0] grant_all;
    logic [S_DATA_COUNT-1:0]              locked_src;

    assign grant_o = grant_all;

    // A source held by any master is invisible to every other arbiter.
    always_comb begin
        locked_src = '0;
        for (int m = 0; m < M_DATA_COUNT; m++)
            locked_src = locked_src | grant_all[m*S_DATA_COUNT +: S_DATA_COUNT];
    end

    // Ready of a source comes from the master that currently owns it.
    always_comb begin
        s_ready_o = '0;
        for (int m = 0; m < M_DATA_COUNT; m++)
            s_ready_o = s_ready_o |
                        (grant_all[m*S_DATA_COUNT +: S_DATA_COUNT] & {S_DATA_COUNT{m_ready_i[m]}});
    end

    // Flag sources whose destination points past the last master.
    always_comb begin
        dest_err_o = '0;
        for (int i = 0; i < S_DATA_COUNT; i++)
            dest_err_o[i] = s_valid_i[i] &&
                            (32'(s_dest_i[i*T_DEST_WIDTH +: T_DEST_WIDTH]) >= M_DATA_COUNT);
    end

    for (genvar gm = 0; gm < M_DATA_COUNT; gm++) begin : g_master
        state_t                  state;
        logic [S_DATA_COUNT-1:0] grant_r;
        logic [S_DATA_COUNT-1:0] req;
        logic [S_DATA_COUNT-1:0] win_oh;
        logic [T_ID___WIDTH-1:0] id_r;
        logic [T_ID___WIDTH-1:0] ptr_r;
        logic [T_ID___WIDTH-1:0] win_idx;
        logic                    win_found;
        logic                    sel_valid;
        logic                    sel_last;
        logic                    xfer_last;

        assign grant_all[gm*S_DATA_COUNT +: S_DATA_COUNT] = grant_r;

        // Unlocked sources that are valid and addressed to this master.
        always_comb begin
            req = '0;
            for (int i = 0; i < S_DATA_COUNT; i++)
                req[i] = s_valid_i[i] && !locked_src[i] &&
                         (s_dest_i[i*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(gm));
        end

        // Scan requesters starting at the RR pointer (or 0 in fixed mode), wrapping.
        always_comb begin
            int                      idx;
            logic [T_ID___WIDTH-1:0] cand;
            win_found = 1'b0;
            win_idx   = '0;
            win_oh    = '0;
            idx       = 0;
            cand      = '0;
            for (int k = 0; k < S_DATA_COUNT; k++) begin
                idx = ((ARB_MODE == 0) ? int'(ptr_r) : 0) + k;
                if (idx >= S_DATA_COUNT)
                    idx = idx - S_DATA_COUNT;
                cand = T_ID___WIDTH'(idx);
                if (!win_found && req[cand]) begin
                    win_found    = 1'b1;
                    win_idx      = cand;
                    win_oh       = '0;
                    win_oh[cand] = 1'b1;
                end
            end
        end

        // Grant is one-hot, so masking selects the owning source's signals.
        assign sel_valid = |(grant_r & s_valid_i);
        assign sel_last  = |(grant_r & s_last_i);
        assign xfer_last = (state == LOCKED) && sel_valid && m_ready_i[gm] && sel_last;

        assign m_valid_o[gm]                           = (state == LOCKED) && sel_valid;
        assign m_last_o[gm]                            = (state == LOCKED) && sel_last;
        assign m_id_o[gm*T_ID___WIDTH +: T_ID___WIDTH] = id_r;
        assign busy_o[gm]                              = (state == LOCKED);

        // Arbiter FSM: lock on a winner, release after the last beat transfers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state   <= IDLE;
                grant_r <= '0;
                id_r    <= '0;
                ptr_r   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (win_found) begin
                            state   <= LOCKED;
                            grant_r <= win_oh;
                            id_r    <= win_idx;
                        end
                    end
                    LOCKED: begin
                        if (xfer_last) begin
                            state   <= IDLE;
                            grant_r <= '0;
                            id_r    <= '0;
                            if (id_r == T_ID___WIDTH'(S_DATA_COUNT - 1))
                                ptr_r <= '0;
                            else
                                ptr_r <= id_r + T_ID___WIDTH'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
